// File: rtl/bin_morph_3x3.sv
// 3x3 binary erosion/dilation on a 1-bit pixel stream.
// Two 1-bit line buffers feed a 3x3 window; output is 2 cycles behind input.
module bin_morph_3x3 #(
  parameter int IMG_WIDTH = 640,
  parameter int MODE      = 0,
  parameter int XW        = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_frame_clken,
  input  logic per_img_Bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_Bit
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH);
  localparam logic [XW-1:0] TWO  = XW'(2);

  logic          vsync_q;
  logic          href_q;
  logic          href_fall;
  logic          vsync_rise;
  logic [XW-1:0] x;
  logic [XW-1:0] y;

  logic [1:0]    mem [IMG_WIDTH];
  logic          in_rng;
  logic [AW-1:0] addr;
  logic [1:0]    rd;
  logic          t0;
  logic          t1;
  logic          t2;

  logic [2:0]    r0;
  logic [2:0]    r1;
  logic [2:0]    r2;
  logic [XW-1:0] xs;
  logic [XW-1:0] ys;
  logic          vs_d1;
  logic          hr_d1;
  logic          ce_d1;

  logic          border;
  logic          res;

  assign href_fall  = href_q & ~per_frame_href;
  assign vsync_rise = per_frame_vsync & ~vsync_q;

  assign in_rng = (x < XMAX);
  assign addr   = x[AW-1:0];
  assign rd     = in_rng ? mem[addr] : 2'b00;
  assign t0     = rd[1];
  assign t1     = rd[0];
  assign t2     = per_img_Bit;

  // Column/row counters with edge detection of href and vsync
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      if (href_fall)
        x <= '0;
      else if (per_frame_clken && x < XMAX)
        x <= x + 1'b1;
      if (vsync_rise)
        y <= '0;
      else if (href_fall && y != '1)
        y <= y + 1'b1;
    end
  end

  // Line buffer: shift {row y-1, current pixel} into the entry just read
  always_ff @(posedge clk) begin
    if (!rst && per_frame_clken && in_rng)
      mem[addr] <= {t1, t2};
  end

  // Stage 1: shift the window one column per pixel and delay framing
  always_ff @(posedge clk) begin
    if (rst) begin
      r0    <= '0;
      r1    <= '0;
      r2    <= '0;
      xs    <= '0;
      ys    <= '0;
      vs_d1 <= 1'b0;
      hr_d1 <= 1'b0;
      ce_d1 <= 1'b0;
    end else begin
      vs_d1 <= per_frame_vsync;
      hr_d1 <= per_frame_href;
      ce_d1 <= per_frame_clken;
      if (per_frame_clken) begin
        r0 <= {r0[1:0], t0};
        r1 <= {r1[1:0], t1};
        r2 <= {r2[1:0], t2};
        xs <= x;
        ys <= y;
      end
    end
  end

  assign border = (ys < TWO) || (xs < TWO) || (xs >= XMAX);
  assign res    = (MODE != 0) ? |{r0, r1, r2} : &{r0, r1, r2};

  // Stage 2: reduce the window, force border pixels to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bit     <= 1'b0;
    end else begin
      post_frame_vsync <= vs_d1;
      post_frame_href  <= hr_d1;
      post_frame_clken <= ce_d1;
      post_img_Bit     <= ce_d1 & ~border & res;
    end
  end

endmodule

// File: tb/tb_bin_morph_3x3.sv
// Scoreboard bench for bin_morph_3x3: erosion and dilation
// instances share one stimulus stream; a monitor pops expected bits.
module tb_bin_morph_3x3;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic vs;
  logic hr;
  logic ce;
  logic bi;

  logic e_vs, e_hr, e_ce, e_bit;
  logic d_vs, d_hr, d_ce, d_bit;

  bin_morph_3x3 #(.IMG_WIDTH(W), .MODE(0), .XW(11)) u_ero (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hr),
    .per_frame_clken(ce), .per_img_Bit(bi),
    .post_frame_vsync(e_vs), .post_frame_href(e_hr),
    .post_frame_clken(e_ce), .post_img_Bit(e_bit)
  );

  bin_morph_3x3 #(.IMG_WIDTH(W), .MODE(1), .XW(11)) u_dil (
    .clk(clk), .rst(rst),
    .per_frame_vsync(vs), .per_frame_href(hr),
    .per_frame_clken(ce), .per_img_Bit(bi),
    .post_frame_vsync(d_vs), .post_frame_href(d_hr),
    .post_frame_clken(d_ce), .post_img_Bit(d_bit)
  );

  int errors = 0;
  int checks = 0;
  int in_cnt = 0;
  int out_e = 0;
  int out_d = 0;
  bit armed = 1'b0;
  bit qe[$];
  bit qd[$];
  logic img [0:5][0:9];

  logic [2:0] h0 = '0;
  logic [2:0] h1 = '0;
  logic rh0 = 1'b1;
  logic rh1 = 1'b1;

  function automatic bit ref_bit(bit dil, int yy, int xx);
    bit acc;
    if (yy < 2 || xx < 2 || xx >= W) return 1'b0;
    acc = !dil;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (dil) acc = acc | img[yy-2+i][xx-2+j];
        else     acc = acc & img[yy-2+i][xx-2+j];
    return acc;
  endfunction

  task automatic cycle(input logic v, input logic h, input logic c,
                       input logic b, input int yy, input int xx);
    vs = v; hr = h; ce = c; bi = b;
    if (c && !rst) begin
      qe.push_back(ref_bit(1'b0, yy, xx));
      qd.push_back(ref_bit(1'b1, yy, xx));
      in_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int hh, input int ww, input bit gap);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    for (int yy = 0; yy < hh; yy++) begin
      for (int xx = 0; xx < ww; xx++) begin
        if (gap) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, img[yy][xx], yy, xx);
      end
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input logic v);
    for (int yy = 0; yy < 6; yy++)
      for (int xx = 0; xx < 10; xx++)
        img[yy][xx] = v;
  endtask

  always @(posedge clk) begin
    h1  <= h0;
    h0  <= {vs, hr, ce};
    rh1 <= rh0;
    rh0 <= rst;
  end

  task automatic chk_sync(input string nm, input logic [2:0] act,
                          input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s sync got=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s bit got=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: framing delay check every cycle, pixel check on clken
  always @(negedge clk) begin
    if (armed) begin
      logic [2:0] ex;
      ex = (rh0 || rh1) ? 3'b000 : h1;
      chk_sync("ero", {e_vs, e_hr, e_ce}, ex);
      chk_sync("dil", {d_vs, d_hr, d_ce}, ex);
      if (e_ce === 1'b1) begin
        out_e++;
        if (qe.size() == 0) begin
          checks++; errors++;
          $display("FAIL ero_underflow got=%b exp=none", e_bit);
        end else chk_bit("ero_pix", e_bit, qe.pop_front());
      end else chk_bit("ero_idle", e_bit, 1'b0);
      if (d_ce === 1'b1) begin
        out_d++;
        if (qd.size() == 0) begin
          checks++; errors++;
          $display("FAIL dil_underflow got=%b exp=none", d_bit);
        end else chk_bit("dil_pix", d_bit, qd.pop_front());
      end else chk_bit("dil_idle", d_bit, 1'b0);
    end
  end

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; vs = 0; hr = 0; ce = 0; bi = 0;
    @(posedge clk);
    #1;
    armed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vs = 1'($urandom); hr = 1'($urandom);
      ce = 1'($urandom); bi = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0);

    fill(1'b1);
    frame(6, 8, 1'b0);
    chk_int("count_all_ones", out_e, 48);

    fill(1'b1);
    img[3][4] = 1'b0;
    frame(6, 8, 1'b0);

    fill(1'b0);
    img[3][4] = 1'b1;
    frame(6, 8, 1'b0);

    fill(1'b1);
    frame(6, 8, 1'b1);

    for (int yy = 0; yy < 6; yy++)
      for (int xx = 0; xx < 10; xx++)
        img[yy][xx] = ((xx * 3 + yy * 5) % 7) != 0;
    frame(4, 10, 1'b0);

    for (int yy = 0; yy < 6; yy++)
      for (int xx = 0; xx < 10; xx++)
        img[yy][xx] = ((xx + 2 * yy) % 5) != 0;
    frame(6, 8, 1'b0);

    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0, 0);
    chk_int("count_ero", out_e, in_cnt);
    chk_int("count_dil", out_d, in_cnt);
    chk_int("left_ero", qe.size(), 0);
    chk_int("left_dil", qd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
